biquad_coeff_sequencer: RTL and testbench

//  Wishbone master that loads coefficient sets into the two-stage biquad chain (biquad8_x2 register window).
//  On start, it optionally pulses the biquad datapath reset, then streams NENTRY-max {addr,data} pairs from a coefficient table.
//  It finishes by writing the update register of both stages so the new coefficients take effect together.
//  It sits between the PS-side control registers and the biquad wrapper's 22-bit/32-bit WB target port.

---
 rtl/biquad_seq_pkg.sv | 36 +++
 rtl/wb_single_write.sv | 96 +++++++++
 rtl/biquad_coeff_sequencer.sv | 172 +++++++++++++++++
 tb/tb_biquad_coeff_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_seq_pkg.sv
// Shared types and constants for the biquad coefficient sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package biquad_seq_pkg;

    localparam int STAGE_SEL_BIT = 7;
    localparam int WB_ADR_W      = 22;
    localparam int WB_DAT_W      = 32;

    // One coefficient table row as read from the table port: {adr, dat}.
    typedef struct packed {
        logic [7:0]  adr;
        logic [31:0] dat;
    } coeff_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BQRST,
        ST_FETCH,
        ST_WRITE,
        ST_WAIT,
        ST_UPD0,
        ST_UPD0W,
        ST_UPD1,
        ST_UPD1W,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_BUSY,
        WR_GAP
    } wr_state_t;

endpackage

// File: rtl/wb_single_write.sv
// Issues one classic Wishbone write, with retry on err/rty and a no-response timeout.
// Latency: strobes rise the cycle after req; ok/fail are combinational pulses in the response cycle.
// Backpressure: req is only honoured while idle; the slave stalls us by withholding ack/err/rty.
//
// Ports: clk/rst_n; req + req_ent launch a write; ok/fail report completion;
//        cyc/stb/we/adr/dat/sel drive the WB slave, ack/err/rty come back from it.
module wb_single_write
    import biquad_seq_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  coeff_entry_t        req_ent,
    output logic                ok,
    output logic                fail,
    output logic                cyc,
    output logic                stb,
    output logic                we,
    output logic [WB_ADR_W-1:0] adr,
    output logic [WB_DAT_W-1:0] dat,
    output logic [3:0]          sel,
    input  logic                ack,
    input  logic                err,
    input  logic                rty
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    wr_state_t          st_q, st_nxt;
    coeff_entry_t       ent_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [RTY_W-1:0]   rty_q;
    logic               bad;
    logic               tmo_hit;

    // err/rty take priority over a simultaneous ack.
    assign bad     = err | rty;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        st_nxt = st_q;
        ok     = 1'b0;
        fail   = 1'b0;
        case (st_q)
            WR_IDLE: if (req) st_nxt = WR_BUSY;
            WR_BUSY: begin
                if (bad) begin
                    if (rty_q == RTY_W'(MAX_RETRY)) begin
                        fail   = 1'b1;
                        st_nxt = WR_IDLE;
                    end else begin
                        st_nxt = WR_GAP;
                    end
                end else if (ack) begin
                    ok     = 1'b1;
                    st_nxt = WR_IDLE;
                end else if (tmo_hit) begin
                    fail   = 1'b1;
                    st_nxt = WR_IDLE;
                end
            end
            WR_GAP:  st_nxt = WR_BUSY;
            default: st_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= WR_IDLE;
            ent_q <= '0;
            tmo_q <= '0;
            rty_q <= '0;
        end else begin
            st_q <= st_nxt;
            if (st_q == WR_IDLE && req) begin
                ent_q <= req_ent;
                rty_q <= '0;
            end else if (st_q == WR_BUSY && bad) begin
                rty_q <= rty_q + 1'b1;
            end
            // Timeout only accumulates across consecutive silent cycles of one issue.
            tmo_q <= (st_q == WR_BUSY && st_nxt == WR_BUSY) ? tmo_q + 1'b1 : '0;
        end
    end

    assign cyc = (st_q == WR_BUSY);
    assign stb = cyc;
    assign we  = cyc;
    assign sel = {4{cyc}};
    assign adr = {{(WB_ADR_W - 8){1'b0}}, ent_q.adr};
    assign dat = ent_q.dat;

endmodule

// File: rtl/biquad_coeff_sequencer.sv
// Loads a coefficient table into the two-stage biquad over Wishbone, then commits both stages.
// Latency: optional RST_CYCLES+1 reset phase, then >=3 cycles per table entry, plus two update writes.
// Backpressure: slave stalls via ack latency; err/rty retried up to MAX_RETRY, silence aborts at TIMEOUT.
//
// Ports: start_i/rst_bq_i/n_entries_i launch a load; tbl_adr_o/tbl_dat_i read the table;
//        wb_* is the WB master; bq_reset_o resets the biquad datapath;
//        busy_o/done_o/error_o/err_idx_o report status.
module biquad_coeff_sequencer
    import biquad_seq_pkg::*;
#(
    parameter int          NENTRY        = 64,
    parameter logic [6:0]  UPDATE_OFFSET = 7'h00,
    parameter logic [31:0] UPDATE_DATA   = 32'h1,
    parameter int          TIMEOUT       = 255,
    parameter int          MAX_RETRY     = 3,
    parameter int          RST_CYCLES    = 16,
    localparam int         TW            = $clog2(NENTRY)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                start_i,
    input  logic                rst_bq_i,
    input  logic [TW:0]         n_entries_i,
    output logic [TW-1:0]       tbl_adr_o,
    input  logic [39:0]         tbl_dat_i,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    output logic [3:0]          wb_sel_o,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_rty_i,
    output logic                bq_reset_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [TW:0]         err_idx_o
);
    localparam int          RCW   = $clog2(RST_CYCLES + 1);
    localparam logic [TW:0] N_MAX = (TW + 1)'(NENTRY);

    state_t         state_q, state_nxt;
    logic [TW:0]    idx_q, idx_nxt, idx_inc, n_q, n_clamp, err_idx_q;
    logic [TW-1:0]  tbl_adr_q;
    logic [RCW-1:0] rst_cnt_q;
    logic           bq_rst_q, error_q;
    logic           busy, launch;
    logic           wr_req, wr_ok, wr_fail;
    coeff_entry_t   wr_ent;

    assign busy    = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign launch  = start_i && !busy;
    assign n_clamp = (n_entries_i > N_MAX) ? N_MAX : n_entries_i;
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        wr_req    = 1'b0;
        wr_ent    = coeff_entry_t'(tbl_dat_i);
        if (launch) begin
            idx_nxt = '0;
            if (rst_bq_i)             state_nxt = ST_BQRST;
            else if (n_clamp == '0)   state_nxt = ST_UPD0;
            else                      state_nxt = ST_FETCH;
        end else begin
            case (state_q)
                // Last count value is the idle gap after bq_reset_o has dropped.
                ST_BQRST: if (rst_cnt_q == RCW'(RST_CYCLES))
                              state_nxt = (n_q == '0) ? ST_UPD0 : ST_FETCH;
                ST_FETCH: state_nxt = ST_WRITE;
                ST_WRITE: begin
                    wr_req    = 1'b1;
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (wr_ok) begin
                        idx_nxt   = idx_inc;
                        state_nxt = (idx_inc == n_q) ? ST_UPD0 : ST_FETCH;
                    end else if (wr_fail) begin
                        state_nxt = ST_ERROR;
                    end
                end
                ST_UPD0, ST_UPD1: begin
                    wr_req     = 1'b1;
                    wr_ent.adr = {1'b0, UPDATE_OFFSET};
                    wr_ent.adr[STAGE_SEL_BIT] = (state_q == ST_UPD1);
                    wr_ent.dat = UPDATE_DATA;
                    state_nxt  = (state_q == ST_UPD0) ? ST_UPD0W : ST_UPD1W;
                end
                // idx keeps counting through the updates so err_idx_o is n / n+1.
                ST_UPD0W: begin
                    if (wr_ok) begin
                        idx_nxt   = idx_inc;
                        state_nxt = ST_UPD1;
                    end else if (wr_fail) begin
                        state_nxt = ST_ERROR;
                    end
                end
                ST_UPD1W: begin
                    if (wr_ok)        state_nxt = ST_DONE;
                    else if (wr_fail) state_nxt = ST_ERROR;
                end
                ST_DONE, ST_ERROR: state_nxt = ST_IDLE;
                default:           state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            tbl_adr_q <= '0;
            rst_cnt_q <= '0;
            bq_rst_q  <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            // Table address only moves when an entry is actually fetched.
            if (state_nxt == ST_FETCH) tbl_adr_q <= idx_nxt[TW-1:0];
            if (launch) begin
                n_q       <= n_clamp;
                bq_rst_q  <= rst_bq_i;
                rst_cnt_q <= '0;
                error_q   <= 1'b0;
                err_idx_q <= '0;
            end else if (state_q == ST_BQRST) begin
                if (rst_cnt_q != RCW'(RST_CYCLES)) rst_cnt_q <= rst_cnt_q + 1'b1;
                if (rst_cnt_q == RCW'(RST_CYCLES - 1)) bq_rst_q <= 1'b0;
            end
            if (wr_fail) begin
                error_q   <= 1'b1;
                err_idx_q <= idx_q;
            end
        end
    end

    wb_single_write #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_wr (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .req     (wr_req),
        .req_ent (wr_ent),
        .ok      (wr_ok),
        .fail    (wr_fail),
        .cyc     (wb_cyc_o),
        .stb     (wb_stb_o),
        .we      (wb_we_o),
        .adr     (wb_adr_o),
        .dat     (wb_dat_o),
        .sel     (wb_sel_o),
        .ack     (wb_ack_i),
        .err     (wb_err_i),
        .rty     (wb_rty_i)
    );

    assign tbl_adr_o  = tbl_adr_q;
    assign bq_reset_o = bq_rst_q;
    assign busy_o     = busy;
    assign done_o     = (state_q == ST_DONE);
    assign error_o    = error_q;
    assign err_idx_o  = err_idx_q;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Directed bench for biquad_coeff_sequencer with a combinational WB slave and a sync-read table.
// Latency: n/a.
// Backpressure: slave can inject err/rty on a chosen address or stay silent on one.
module tb_biquad_coeff_sequencer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        rst_bq_i = 1'b0;
    logic [6:0]  n_entries_i = '0;
    logic [5:0]  tbl_adr_o;
    logic [39:0] tbl_dat;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [21:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        bq_reset_o, busy_o, done_o, error_o;
    logic [6:0]  err_idx_o;

    always #5 wb_clk_i = ~wb_clk_i;

    biquad_coeff_sequencer dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n_i  (wb_rst_n_i),
        .start_i     (start_i),
        .rst_bq_i    (rst_bq_i),
        .n_entries_i (n_entries_i),
        .tbl_adr_o   (tbl_adr_o),
        .tbl_dat_i   (tbl_dat),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_rty_i    (wb_rty_i),
        .bq_reset_o  (bq_reset_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .err_idx_o   (err_idx_o)
    );

    // Coefficient table, one-cycle read latency.
    logic [39:0] tbl [64];
    always @(posedge wb_clk_i) tbl_dat <= tbl[tbl_adr_o];

    // Slave configuration, written by the stimulus block only.
    logic       fault_en = 1'b0, fault_rty = 1'b0, hang_en = 1'b0, clr_log = 1'b0;
    logic [7:0] fault_adr = '0, hang_adr = '0;
    int         fault_cnt = 0;

    // Monitor state, written by the monitor only.
    int          fault_hits, att_n, acc_n, bq_hi, cyc_hi, done_cnt, adr_chg, ovl;
    logic [21:0] att_adr [16];
    logic [31:0] att_dat [16];
    logic [21:0] acc_adr [16];
    logic [31:0] acc_dat [16];
    logic [5:0]  tbl_adr_prev;

    logic fault_now, hang_now;
    always_comb begin
        fault_now = wb_cyc_o && wb_stb_o && fault_en && (wb_adr_o[7:0] == fault_adr)
                    && (fault_hits < fault_cnt);
        hang_now  = hang_en && (wb_adr_o[7:0] == hang_adr);
        wb_err_i  = fault_now && !fault_rty;
        wb_rty_i  = fault_now && fault_rty;
        // An err fault arrives together with ack, so err must win inside the DUT.
        wb_ack_i  = wb_cyc_o && wb_stb_o && !hang_now && !(fault_now && fault_rty);
    end

    always @(posedge wb_clk_i) begin
        if (clr_log) begin
            fault_hits <= 0; att_n <= 0; acc_n <= 0; bq_hi <= 0;
            cyc_hi <= 0; done_cnt <= 0; adr_chg <= 0; ovl <= 0;
        end else begin
            if (bq_reset_o) bq_hi <= bq_hi + 1;
            if (wb_cyc_o) cyc_hi <= cyc_hi + 1;
            if (wb_cyc_o && bq_reset_o) ovl <= ovl + 1;
            if (done_o) done_cnt <= done_cnt + 1;
            if (tbl_adr_o != tbl_adr_prev) adr_chg <= adr_chg + 1;
            if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i)) begin
                if (att_n < 16) begin
                    att_adr[att_n] <= wb_adr_o;
                    att_dat[att_n] <= wb_dat_o;
                end
                att_n <= att_n + 1;
                if (wb_err_i || wb_rty_i) begin
                    fault_hits <= fault_hits + 1;
                end else begin
                    if (acc_n < 16) begin
                        acc_adr[acc_n] <= wb_adr_o;
                        acc_dat[acc_n] <= wb_dat_o;
                    end
                    acc_n <= acc_n + 1;
                end
            end
        end
        tbl_adr_prev <= tbl_adr_o;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic kick(input logic rb, input int n);
        @(negedge wb_clk_i);
        start_i = 1'b1; rst_bq_i = rb; n_entries_i = 7'(n); clr_log = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0; rst_bq_i = 1'b0; clr_log = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge wb_clk_i);
            if (done_o || error_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic settle;
        repeat (2) @(negedge wb_clk_i);
    endtask

    initial begin
        tbl[0] = {8'h05, 32'h1111_1111};
        tbl[1] = {8'h06, 32'h2222_2222};
        tbl[2] = {8'h85, 32'h3333_3333};
        tbl[3] = {8'h07, 32'h4444_4444};
        for (int i = 4; i < 64; i++) tbl[i] = {8'(i), 32'(i)};

        // Reset state
        repeat (3) @(negedge wb_clk_i);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_we", wb_we_o, 1'b0);
        chk("rst_sel", wb_sel_o, 4'h0);
        chk("rst_adr", wb_adr_o, 22'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_bq", bq_reset_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", error_o, 1'b0);
        chk("rst_eidx", err_idx_o, 7'h0);
        chk("rst_tadr", tbl_adr_o, 6'h0);
        wb_rst_n_i = 1'b1;

        // 1: datapath reset, three entries, two updates
        kick(1'b1, 3);
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_bq_on", bq_reset_o, 1'b1);
        wait_end("t1_end");
        chk("t1_err", error_o, 1'b0);
        settle();
        chk("t1_bq_len", 32'(bq_hi), 32'd16);
        chk("t1_overlap", 32'(ovl), 32'd0);
        chk("t1_nacc", 32'(acc_n), 32'd5);
        chk("t1_a0", acc_adr[0], 22'h05);
        chk("t1_d0", acc_dat[0], 32'h1111_1111);
        chk("t1_a1", acc_adr[1], 22'h06);
        chk("t1_d1", acc_dat[1], 32'h2222_2222);
        chk("t1_a2", acc_adr[2], 22'h85);
        chk("t1_d2", acc_dat[2], 32'h3333_3333);
        chk("t1_a3", acc_adr[3], 22'h00);
        chk("t1_d3", acc_dat[3], 32'h1);
        chk("t1_a4", acc_adr[4], 22'h80);
        chk("t1_d4", acc_dat[4], 32'h1);
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_idle", busy_o, 1'b0);

        // 2: update-only
        kick(1'b0, 0);
        wait_end("t2_end");
        settle();
        chk("t2_nacc", 32'(acc_n), 32'd2);
        chk("t2_a0", acc_adr[0], 22'h00);
        chk("t2_a1", acc_adr[1], 22'h80);
        chk("t2_d1", acc_dat[1], 32'h1);
        chk("t2_tadr", 32'(adr_chg), 32'd0);
        chk("t2_done", 32'(done_cnt), 32'd1);
        chk("t2_bq", 32'(bq_hi), 32'd0);

        // 3: err (with coincident ack) on first try of entry 1
        fault_en = 1'b1; fault_rty = 1'b0; fault_adr = 8'h06; fault_cnt = 1;
        kick(1'b0, 3);
        wait_end("t3_end");
        chk("t3_err", error_o, 1'b0);
        settle();
        chk("t3_natt", 32'(att_n), 32'd6);
        chk("t3_nacc", 32'(acc_n), 32'd5);
        chk("t3_a1", att_adr[1], 22'h06);
        chk("t3_a2", att_adr[2], 22'h06);
        chk("t3_d1", att_dat[1], 32'h2222_2222);
        chk("t3_d2", att_dat[2], 32'h2222_2222);
        chk("t3_a3", att_adr[3], 22'h85);
        chk("t3_done", 32'(done_cnt), 32'd1);
        fault_en = 1'b0;

        // 4: silent slave on entry 2 -> timeout
        hang_en = 1'b1; hang_adr = 8'h85;
        kick(1'b0, 3);
        wait_end("t4_end");
        chk("t4_err", error_o, 1'b1);
        chk("t4_eidx", err_idx_o, 7'd2);
        chk("t4_cyc", wb_cyc_o, 1'b0);
        chk("t4_stb", wb_stb_o, 1'b0);
        chk("t4_busy", busy_o, 1'b0);
        settle();
        chk("t4_cyc_hi", 32'(cyc_hi), 32'd257);
        chk("t4_done", 32'(done_cnt), 32'd0);
        chk("t4_sticky", error_o, 1'b1);
        hang_en = 1'b0;

        // 5: rty four times on stage1 update
        fault_en = 1'b1; fault_rty = 1'b1; fault_adr = 8'h80; fault_cnt = 4;
        kick(1'b0, 2);
        wait_end("t5_end");
        chk("t5_err", error_o, 1'b1);
        chk("t5_eidx", err_idx_o, 7'd3);
        settle();
        chk("t5_natt", 32'(att_n), 32'd7);
        chk("t5_nacc", 32'(acc_n), 32'd3);
        chk("t5_done", 32'(done_cnt), 32'd0);
        fault_en = 1'b0;
        kick(1'b0, 0);
        chk("t5_clr", error_o, 1'b0);
        chk("t5_clr_idx", err_idx_o, 7'd0);
        wait_end("t5b_end");
        chk("t5b_done", done_o, 1'b1);

        // 6: start while busy, then async reset mid-WAIT
        hang_en = 1'b1; hang_adr = 8'h05;
        kick(1'b0, 3);
        repeat (3) @(negedge wb_clk_i);
        start_i = 1'b1; rst_bq_i = 1'b1; n_entries_i = 7'd0;
        @(negedge wb_clk_i);
        start_i = 1'b0; rst_bq_i = 1'b0;
        @(negedge wb_clk_i);
        chk("t6_busy", busy_o, 1'b1);
        chk("t6_nobq", bq_reset_o, 1'b0);
        chk("t6_cyc", wb_cyc_o, 1'b1);
        chk("t6_adr", wb_adr_o, 22'h05);
        #2 wb_rst_n_i = 1'b0;
        #1;
        chk("t6_rcyc", wb_cyc_o, 1'b0);
        chk("t6_rstb", wb_stb_o, 1'b0);
        chk("t6_rbusy", busy_o, 1'b0);
        chk("t6_rdone", done_o, 1'b0);
        chk("t6_radr", wb_adr_o, 22'h0);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1; hang_en = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        chk("t6_idle", busy_o, 1'b0);
        chk("t6_nocyc", wb_cyc_o, 1'b0);
        chk("t6_nodone", 32'(done_cnt), 32'd0);

        // 7: n above NENTRY is clamped to 64 entries
        kick(1'b0, 100);
        wait_end("t7_end");
        chk("t7_err", error_o, 1'b0);
        settle();
        chk("t7_nacc", 32'(acc_n), 32'd66);
        chk("t7_a4", acc_adr[4], 22'h04);
        chk("t7_d4", acc_dat[4], 32'h4);
        chk("t7_done", 32'(done_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
